// File: rtl/fpu_tag_issuer.sv
// fpu_tag_issuer: hands out free FPU tags, parks per-request metadata by tag and restores it
// when out-of-order FPU results return. Define FPU_FFLAGS_ACC_EN for the sticky fflags accumulator.
`ifndef INST_FPU_BITS
`define INST_FPU_BITS 4
`endif
`ifndef INST_MOD_BITS
`define INST_MOD_BITS 3
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 2
`endif

module fpu_tag_issuer #(
  parameter int TAGW  = 4,
  parameter int METAW = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [METAW-1:0]            req_meta,
  input  logic [`INST_FPU_BITS-1:0]   req_op_type,
  input  logic [`INST_MOD_BITS-1:0]   req_frm,
  input  logic [`NUM_THREADS*32-1:0]  req_dataa,
  input  logic [`NUM_THREADS*32-1:0]  req_datab,
  input  logic [`NUM_THREADS*32-1:0]  req_datac,
  output logic                        fpu_valid_in,
  input  logic                        fpu_ready_in,
  output logic [TAGW-1:0]             fpu_tag_in,
  output logic [`INST_FPU_BITS-1:0]   fpu_op_type,
  output logic [`INST_MOD_BITS-1:0]   fpu_frm,
  output logic [`NUM_THREADS*32-1:0]  fpu_dataa,
  output logic [`NUM_THREADS*32-1:0]  fpu_datab,
  output logic [`NUM_THREADS*32-1:0]  fpu_datac,
  input  logic                        fpu_valid_out,
  output logic                        fpu_ready_out,
  input  logic [TAGW-1:0]             fpu_tag_out,
  input  logic [`NUM_THREADS*32-1:0]  fpu_result,
  input  logic                        fpu_has_fflags,
  input  logic [`NUM_THREADS*5-1:0]   fpu_fflags,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [METAW-1:0]            rsp_meta,
  output logic [`NUM_THREADS*32-1:0]  rsp_result,
  output logic                        rsp_has_fflags,
  output logic [`NUM_THREADS*5-1:0]   rsp_fflags,
`ifdef FPU_FFLAGS_ACC_EN
  input  logic                        fflags_clr,
  output logic [4:0]                  fflags_acc,
`endif
  output logic [TAGW:0]               pending,
  output logic                        idle
);

  localparam int DEPTH = 1 << TAGW;
  localparam int NT    = `NUM_THREADS;
  localparam logic [TAGW:0] ONE   = (TAGW+1)'(1);
  localparam logic [TAGW:0] FULLC = (TAGW+1)'(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [METAW-1:0] meta_table [DEPTH];
  logic [TAGW-1:0]  alloc_tag;
  logic             full;
  logic             issue_fire;
  logic             rsp_fire;
  logic             release_ok;

  assign full          = (pending == FULLC);
  assign fpu_valid_in  = req_valid & ~full;
  assign req_ready     = fpu_ready_in & ~full;
  assign issue_fire    = req_valid & req_ready;
  assign fpu_tag_in    = alloc_tag;
  assign fpu_op_type   = req_op_type;
  assign fpu_frm       = req_frm;
  assign fpu_dataa     = req_dataa;
  assign fpu_datab     = req_datab;
  assign fpu_datac     = req_datac;
  assign fpu_ready_out = ~rsp_valid | rsp_ready;
  assign rsp_fire      = fpu_valid_out & fpu_ready_out;
  // A result for an idle tag is still forwarded, but must not disturb the bookkeeping.
  assign release_ok    = rsp_fire & busy[fpu_tag_out];
  assign idle          = (pending == '0) & ~rsp_valid;

  // Scan high to low so the lowest clear bit wins.
  always_comb begin
    alloc_tag = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_tag = TAGW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= '0;
      pending <= '0;
    end else begin
      if (release_ok) busy[fpu_tag_out] <= 1'b0;
      if (issue_fire) busy[alloc_tag]   <= 1'b1;
      case ({issue_fire, release_ok})
        2'b10:   pending <= pending + ONE;
        2'b01:   pending <= pending - ONE;
        default: pending <= pending;
      endcase
    end
  end

  // Contents are meaningless until written, so the table carries no reset.
  always_ff @(posedge clk) begin
    if (issue_fire) meta_table[alloc_tag] <= req_meta;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid      <= 1'b0;
      rsp_meta       <= '0;
      rsp_result     <= '0;
      rsp_has_fflags <= 1'b0;
      rsp_fflags     <= '0;
    end else if (rsp_fire) begin
      rsp_valid      <= 1'b1;
      rsp_meta       <= meta_table[fpu_tag_out];
      rsp_result     <= fpu_result;
      rsp_has_fflags <= fpu_has_fflags;
      rsp_fflags     <= fpu_fflags;
    end else if (rsp_ready) begin
      rsp_valid      <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!reset && rsp_fire)
      assert (busy[fpu_tag_out])
        else $error("fpu_tag_issuer: result for idle tag %0d", fpu_tag_out);
  end

`ifdef FPU_FFLAGS_ACC_EN
  logic [4:0] lane_or;

  always_comb begin
    lane_or = '0;
    for (int i = 0; i < NT; i++) lane_or = lane_or | rsp_fflags[i*5 +: 5];
  end

  // Clear and accumulate together: this cycle's flags survive the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fflags_acc <= '0;
    end else if (rsp_valid && rsp_ready && rsp_has_fflags) begin
      fflags_acc <= (fflags_clr ? 5'b0 : fflags_acc) | lane_or;
    end else if (fflags_clr) begin
      fflags_acc <= '0;
    end
  end
`endif

endmodule
